dds_freq_meter: RTL and testbench

//   Receive-side counterpart of the DDS generator: measures the 8-bit waveform stream (DDS data_out

---
 rtl/dds_freq_meter.sv | 160 ++++++++++++++++
 tb/tb_dds_freq_meter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dds_freq_meter.sv
// Reciprocal frequency meter for an unsigned sample stream: hysteresis crossing detector,
// period count over 2**CYC_LOG2 signal periods, peak tracking and a no-signal timeout.
module dds_freq_meter #(
   parameter int DATA_W       = 8,
   parameter int MID          = 128,
   parameter int HYST         = 8,
   parameter int CYC_LOG2     = 4,
   parameter int CNT_W        = 32,
   parameter int TIMEOUT_CLKS = 24_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  period_cnt,
   output logic [DATA_W-1:0] peak_max,
   output logic [DATA_W-1:0] peak_min
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

   localparam int                TO_W      = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [DATA_W-1:0] HI_TH     = DATA_W'(MID + HYST);
   localparam logic [DATA_W-1:0] LO_TH     = DATA_W'(MID - HYST);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [CYC_LOG2-1:0] EDGE_LAST = '1;

   state_t              state_q, state_d;
   logic                flag_q, flag_d;
   logic                rise_q, rise_d;
   logic [CYC_LOG2-1:0] edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]    per_cnt_q, per_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [DATA_W-1:0]   run_max_q, run_max_d;
   logic [DATA_W-1:0]   run_min_q, run_min_d;
   logic                done_q, done_d;
   logic                timeout_q, timeout_d;
   logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
   logic [DATA_W-1:0]   peak_max_q, peak_max_d;
   logic [DATA_W-1:0]   peak_min_q, peak_min_d;

   logic start_ok, meas_done, expire;

   // A start landing in the done/timeout cycle is dropped.
   assign start_ok  = (state_q == S_IDLE) && start && !done_q && !timeout_q;
   assign meas_done = (state_q == S_MEAS) && rise_q && (edge_cnt_q == EDGE_LAST);
   assign expire    = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok) state_d = S_ARM;
         S_ARM:   if (expire) state_d = S_IDLE;
                  else if (rise_q) state_d = S_MEAS;
         S_MEAS:  if (meas_done || expire) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_ARM) || (state_q == S_MEAS);
   end

   always_comb begin
      flag_d       = flag_q;
      edge_cnt_d   = edge_cnt_q;
      per_cnt_d    = per_cnt_q;
      to_cnt_d     = to_cnt_q;
      run_max_d    = run_max_q;
      run_min_d    = run_min_q;
      period_cnt_d = period_cnt_q;
      peak_max_d   = peak_max_q;
      peak_min_d   = peak_min_q;
      done_d       = meas_done;
      timeout_d    = expire && !meas_done;

      if (sample_valid) begin
         if (sample_in >= HI_TH)     flag_d = 1'b1;
         else if (sample_in < LO_TH) flag_d = 1'b0;
      end
      rise_d = flag_d && !flag_q;

      if (start_ok) begin
         to_cnt_d  = TO_W'(1);
         run_max_d = '0;
         run_min_d = '1;
      end

      if (busy) begin
         to_cnt_d = to_cnt_q + 1'b1;
         if (sample_valid) begin
            if (sample_in > run_max_q) run_max_d = sample_in;
            if (sample_in < run_min_q) run_min_d = sample_in;
         end
      end

      // per_cnt_q reads 1 the cycle after t0, so it equals (now - t0) on each later rise.
      if (state_q == S_ARM && rise_q) begin
         edge_cnt_d = '0;
         per_cnt_d  = CNT_W'(1);
      end else if (state_q == S_MEAS) begin
         if (per_cnt_q != '1) per_cnt_d = per_cnt_q + 1'b1;
         if (rise_q)          edge_cnt_d = edge_cnt_q + 1'b1;
      end

      if (meas_done) begin
         period_cnt_d = per_cnt_q;
         peak_max_d   = run_max_q;
         peak_min_d   = run_min_q;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         flag_q       <= 1'b0;
         rise_q       <= 1'b0;
         edge_cnt_q   <= '0;
         per_cnt_q    <= '0;
         to_cnt_q     <= '0;
         run_max_q    <= '0;
         run_min_q    <= '1;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         period_cnt_q <= '0;
         peak_max_q   <= '0;
         peak_min_q   <= '0;
      end else begin
         flag_q       <= flag_d;
         rise_q       <= rise_d;
         edge_cnt_q   <= edge_cnt_d;
         per_cnt_q    <= per_cnt_d;
         to_cnt_q     <= to_cnt_d;
         run_max_q    <= run_max_d;
         run_min_q    <= run_min_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         period_cnt_q <= period_cnt_d;
         peak_max_q   <= peak_max_d;
         peak_min_q   <= peak_min_d;
      end
   end

   assign done       = done_q;
   assign timeout    = timeout_q;
   assign period_cnt = period_cnt_q;
   assign peak_max   = peak_max_q;
   assign peak_min   = peak_min_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter: table of square/sine runs plus start, reset,
// timeout and counter-saturation sequences.
module tb_dds_freq_meter;

   logic        sys_clk = 1'b0;
   logic        sys_rst, sample_valid, start;
   logic [7:0]  sample_in;
   logic        busy, done, timeout;
   logic [31:0] period_cnt;
   logic [7:0]  peak_max, peak_min;
   logic        s_busy, s_done, s_timeout;
   logic [7:0]  s_period, s_max, s_min;

   dds_freq_meter #(.TIMEOUT_CLKS(5000)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_in(sample_in),
      .sample_valid(sample_valid), .start(start), .busy(busy), .done(done),
      .timeout(timeout), .period_cnt(period_cnt), .peak_max(peak_max), .peak_min(peak_min)
   );

   // Narrow period counter: every run in the table overflows it.
   dds_freq_meter #(.CNT_W(8), .TIMEOUT_CLKS(5000)) dut_sat (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_in(sample_in),
      .sample_valid(sample_valid), .start(start), .busy(s_busy), .done(s_done),
      .timeout(s_timeout), .period_cnt(s_period), .peak_max(s_max), .peak_min(s_min)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int mode;       // 0 square low-first, 1 sine, 2 alternating lo/hi
      int lo, hi, half, vev;
      int exp_period, exp_max, exp_min, exp_lat;
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] sine_lut [64];
   int         checks = 0, errors = 0;
   int         p, cyc;
   int         g_mode = 0, g_lo = 0, g_hi = 255, g_half = 32, g_vev = 1;

   function automatic logic [7:0] gen(int k);
      case (g_mode)
         0:       return ((k / g_half) % 2 != 0) ? 8'(g_hi) : 8'(g_lo);
         1:       return sine_lut[k % 64];
         default: return (k % 2 != 0) ? 8'(g_hi) : 8'(g_lo);
      endcase
   endfunction

   // One clock: drive sample at negedge, then return 1 time unit after posedge.
   task automatic step();
      @(negedge sys_clk);
      if (p % g_vev == 0) begin
         sample_valid = 1'b1;
         sample_in    = gen(p / g_vev);
      end else begin
         sample_valid = 1'b0;
         sample_in    = (gen(p / g_vev) < 8'd128) ? 8'd250 : 8'd5;
      end
      p++;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic start_run(input vec_t v);
      g_mode = v.mode; g_lo = v.lo; g_hi = v.hi; g_half = v.half; g_vev = v.vev;
      p = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_end(input int bud);
      while (!(done || timeout) && cyc < bud) begin
         step();
         cyc++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag, input bit do_rst);
      int extra;
      if (do_rst) begin
         sys_rst = 1'b1;
         step();
         step();
         sys_rst = 1'b0;
         check({tag, ".rst_state"},
               {busy, done, timeout, period_cnt, peak_max, peak_min}, 64'd0);
      end
      start_run(v);
      wait_end(v.exp_lat + 200);
      check({tag, ".done"},      done,       1);
      check({tag, ".timeout"},   timeout,    0);
      check({tag, ".latency"},   cyc,        v.exp_lat);
      check({tag, ".busy_done"}, busy,       0);
      check({tag, ".period"},    period_cnt, v.exp_period);
      check({tag, ".peak_max"},  peak_max,   v.exp_max);
      check({tag, ".peak_min"},  peak_min,   v.exp_min);
      check({tag, ".sat_period"}, s_period, (v.exp_period > 255) ? 255 : v.exp_period);
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) extra++;
      end
      check({tag, ".single_done"}, extra, 0);
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < 64; i++)
         sine_lut[i] = 8'($rtoi(128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5));

      //            mode lo   hi   half vev period max  min  lat
      vecs[0] = '{0,   0,   255, 32,  1,  1024,  255, 0,   1058};
      vecs[1] = '{1,   0,   0,   0,   1,  1024,  228, 28,  1027};
      vecs[2] = '{0,   40,  200, 16,  2,  1024,  200, 40,  1058};
      vecs[3] = '{0,   119, 136, 8,   1,  256,   136, 119, 266};
      vecs[4] = '{0,   10,  250, 64,  1,  2048,  250, 10,  2114};

      sys_rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_in = 8'd0; p = 0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

      // start during MEAS and in the done cycle are both ignored
      sys_rst = 1'b1; step(); sys_rst = 1'b0;
      start_run(vecs[0]);
      while (cyc < 300) begin step(); cyc++; end
      check("meas.busy", busy, 1);
      start = 1'b1; step(); cyc++; start = 1'b0;
      wait_end(1300);
      check("restart.done",    done, 1);
      check("restart.latency", cyc,  1058);
      start = 1'b1; step(); start = 1'b0;
      check("start_in_done.busy", busy, 0);
      step(); step();
      check("start_in_done.busy_later", busy, 0);

      // synchronous reset in the middle of a run
      start_run(vecs[0]);
      while (cyc < 400) begin step(); cyc++; end
      sys_rst = 1'b1; step(); sys_rst = 1'b0;
      check("midrst.outputs",
            {busy, done, timeout, period_cnt, peak_max, peak_min}, 64'd0);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (done || timeout || busy) pulses++;
      end
      check("midrst.quiet", pulses, 0);
      run_vec(vecs[0], "after_rst", 1'b0);

      // no crossings: 124/132 stays inside the hysteresis band
      start_run('{2, 124, 132, 1, 1, 0, 0, 0, 0});
      wait_end(5100);
      check("to.timeout",  timeout,    1);
      check("to.latency",  cyc,        5000);
      check("to.done",     done,       0);
      check("to.busy",     busy,       0);
      check("to.period",   period_cnt, 1024);
      check("to.peak_max", peak_max,   255);
      check("to.peak_min", peak_min,   0);
      step();
      check("to.one_cycle", timeout, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
